// File: rtl/pref_pkg.sv
// rtl/pref_pkg.sv - shared prefetch address types and block alignment helper
package pref_pkg;

   localparam int ADDR_SIZE       = 64;
   localparam int LOG2_BLOCK_SIZE = 6;

   typedef logic [ADDR_SIZE-1:0] addr_t;

   function automatic addr_t block_align(input addr_t a);
      return {a[ADDR_SIZE-1:LOG2_BLOCK_SIZE], {LOG2_BLOCK_SIZE{1'b0}}};
   endfunction

endpackage

// File: rtl/pref_issue_queue_if.sv
// rtl/pref_issue_queue_if.sv - candidate input and prefetch issue bundle of the issue queue
interface pref_issue_queue_if #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
);
   import pref_pkg::*;

   addr_t                      pref_addr1_i;
   logic                       pref_valid1_i;
   addr_t                      pref_addr2_i;
   logic                       pref_valid2_i;
   addr_t                      pref_addr3_i;
   logic                       pref_valid3_i;
   addr_t                      pf_addr_o;
   logic                       pf_valid_o;
   logic                       pf_ready_i;
   logic [$clog2(DEPTH+1)-1:0] occupancy_o;
   logic [CNT_W-1:0]           drop_count_o;

   modport master (
      output pref_addr1_i, pref_valid1_i, pref_addr2_i, pref_valid2_i,
             pref_addr3_i, pref_valid3_i, pf_ready_i,
      input  pf_addr_o, pf_valid_o, occupancy_o, drop_count_o
   );

   modport slave (
      input  pref_addr1_i, pref_valid1_i, pref_addr2_i, pref_valid2_i,
             pref_addr3_i, pref_valid3_i, pf_ready_i,
      output pf_addr_o, pf_valid_o, occupancy_o, drop_count_o
   );

endinterface

// File: rtl/pref_recent_filter.sv
// rtl/pref_recent_filter.sv - FIFO-replaced CAM of recently enqueued block addresses
module pref_recent_filter
   import pref_pkg::*;
#(
   parameter int FILTER_ENTRIES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  addr_t      lookup_addr [3],
   input  logic [2:0] ins_en,
   input  addr_t      ins_addr [3],
   output logic [2:0] hit
);
   localparam int FW = $clog2(FILTER_ENTRIES);

   addr_t                     tags [FILTER_ENTRIES];
   logic [FILTER_ENTRIES-1:0] valid;
   logic [FW-1:0]             ptr;
   logic [FW-1:0]             ptr_next;
   logic [FW-1:0]             slot [3];

   // Lookups see only the state at the start of the cycle.
   always_comb begin
      hit = '0;
      for (int i = 0; i < 3; i++) begin
         for (int e = 0; e < FILTER_ENTRIES; e++) begin
            if (valid[e] && tags[e] == lookup_addr[i]) hit[i] = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_next = ptr;
      for (int i = 0; i < 3; i++) begin
         slot[i] = ptr_next;
         if (ins_en[i]) begin
            ptr_next = (ptr_next == FW'(FILTER_ENTRIES-1)) ? '0 : ptr_next + FW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= '0;
         ptr   <= '0;
      end else if (flush) begin
         valid <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (ins_en[i]) valid[slot[i]] <= 1'b1;
         end
         ptr <= ptr_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!flush) begin
         for (int i = 0; i < 3; i++) begin
            if (ins_en[i]) tags[slot[i]] <= ins_addr[i];
         end
      end
   end

endmodule

// File: rtl/pref_issue_queue.sv
// rtl/pref_issue_queue.sv - dedups prefetch candidates and issues them one per cycle from a FIFO
module pref_issue_queue
   import pref_pkg::*;
#(
   parameter int DEPTH          = 8,
   parameter int FILTER_ENTRIES = 16,
   parameter int CNT_W          = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   pref_issue_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   addr_t            mem [DEPTH];
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [CW-1:0]    count;
   logic [CNT_W-1:0] drop_count;

   addr_t          cand [3];
   logic [2:0]     cand_v;
   logic [2:0]     hit;
   logic [2:0]     elig;
   logic [2:0]     acc;
   logic [PW-1:0]  slot [3];
   logic [CW-1:0]  free;
   logic [CW-1:0]  n_elig;
   logic [CW-1:0]  n_acc;
   logic [CNT_W:0] drop_sum;
   logic           deq;

   always_comb begin
      cand[0] = block_align(bus.pref_addr1_i);
      cand[1] = block_align(bus.pref_addr2_i);
      cand[2] = block_align(bus.pref_addr3_i);
      cand_v  = {bus.pref_valid3_i, bus.pref_valid2_i, bus.pref_valid1_i};
   end

   pref_recent_filter #(.FILTER_ENTRIES(FILTER_ENTRIES)) u_filter (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush_i),
      .lookup_addr (cand),
      .ins_en      (acc & {3{~flush_i}}),
      .ins_addr    (cand),
      .hit         (hit)
   );

   // Free space is taken from the registered count, so a same-cycle dequeue never makes room.
   always_comb begin
      free   = CW'(DEPTH) - count;
      n_elig = '0;
      n_acc  = '0;
      elig   = '0;
      acc    = '0;
      for (int i = 0; i < 3; i++) begin
         elig[i] = cand_v[i] & ~hit[i];
         for (int j = 0; j < i; j++) begin
            if (elig[j] && cand[j] == cand[i]) elig[i] = 1'b0;
         end
         slot[i] = tail + PW'(n_acc);
         if (elig[i]) begin
            n_elig = n_elig + CW'(1);
            if (n_acc < free) begin
               acc[i] = 1'b1;
               n_acc  = n_acc + CW'(1);
            end
         end
      end
      drop_sum = {1'b0, drop_count} + (CNT_W+1)'(n_elig - n_acc);
   end

   assign deq              = bus.pf_valid_o & bus.pf_ready_i;
   assign bus.pf_valid_o   = (count != '0);
   assign bus.pf_addr_o    = mem[head];
   assign bus.occupancy_o  = count;
   assign bus.drop_count_o = drop_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         drop_count <= '0;
      end else if (flush_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head       <= head + PW'(deq);
         tail       <= tail + PW'(n_acc);
         count      <= count + n_acc - CW'(deq);
         drop_count <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!flush_i) begin
         for (int i = 0; i < 3; i++) begin
            if (acc[i]) mem[slot[i]] <= cand[i];
         end
      end
   end

endmodule
